// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator array: FSM state, saturation limits, lane slicing.
package acc_pkg;

    typedef enum logic [0:0] {
        ACC_IDLE  = 1'b0,
        ACC_DRAIN = 1'b1
    } acc_state_e;

    localparam int unsigned MaxDataW = 64;

    // Limits are returned at MaxDataW; callers cast down to their lane width.
    function automatic logic [MaxDataW-1:0] sat_max(int unsigned w);
        return (MaxDataW'(1) << (w - 1)) - MaxDataW'(1);
    endfunction

    function automatic logic [MaxDataW-1:0] sat_min(int unsigned w);
        return MaxDataW'(1) << (w - 1);
    endfunction

    function automatic int unsigned lane_lsb(int unsigned lane, int unsigned w);
        return lane * w;
    endfunction

endpackage

// File: rtl/accumulator_array_if.sv
// Accumulate beat, drain command and drain output stream between controller, MAC array and buffer.
interface accumulator_array_if #(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LANE_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;

    logic                       acc_valid;
    logic                       acc_ready;
    logic                       acc_first;
    logic [ADDR_W-1:0]          acc_addr;
    logic [ARR_SIZE*DATA_W-1:0] acc_data;

    logic                       drain_start;
    logic [ADDR_W-1:0]          drain_base;
    logic [ADDR_W:0]            drain_rows;
    logic                       drain_clear;

    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [ADDR_W+LANE_W-1:0]   out_addr;
    logic                       out_last;

    logic                       busy;
    logic                       overflow;

    modport master (
        output acc_valid, acc_first, acc_addr, acc_data,
        output drain_start, drain_base, drain_rows, drain_clear,
        output out_ready,
        input  acc_ready, out_valid, out_data, out_addr, out_last, busy, overflow
    );

    modport slave (
        input  acc_valid, acc_first, acc_addr, acc_data,
        input  drain_start, drain_base, drain_rows, drain_clear,
        input  out_ready,
        output acc_ready, out_valid, out_data, out_addr, out_last, busy, overflow
    );

endinterface

// File: rtl/acc_lane_add.sv
// One lane of the accumulate datapath: signed add with wrap or saturation and an overflow flag.
module acc_lane_add
    import acc_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] SatMax = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] SatMin = DATA_W'(sat_min(DATA_W));

    logic [DATA_W:0] full;

    always_comb begin
        full = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        // Sign-extended sum: the top two bits disagree exactly when the DATA_W result overflows.
        ovf  = full[DATA_W] ^ full[DATA_W-1];
        sum  = full[DATA_W-1:0];
        if (SATURATE && ovf) begin
            sum = full[DATA_W] ? SatMin : SatMax;
        end
    end

endmodule

// File: rtl/accumulator_array.sv
// DEPTH x ARR_SIZE signed accumulator rows with add/overwrite beats and a row-range drain stream.
module accumulator_array
    import acc_pkg::*;
#(
    parameter int unsigned ARR_SIZE = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter bit          SATURATE = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    accumulator_array_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LANE_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam int unsigned RowsW  = ADDR_W + 1;
    localparam logic [LANE_W-1:0] LaneMax = LANE_W'(ARR_SIZE - 1);

    acc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d;
    logic [RowsW-1:0]  rows_left_q, rows_left_d;
    logic              clear_q, clear_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] mem_q [DEPTH][ARR_SIZE];

    logic [DATA_W-1:0]   lane_in  [ARR_SIZE];
    logic [DATA_W-1:0]   lane_old [ARR_SIZE];
    logic [DATA_W-1:0]   lane_sum [ARR_SIZE];
    logic [ARR_SIZE-1:0] lane_ovf;

    logic acc_fire;
    logic clr_fire;

    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
        assign lane_in[i]  = bus.acc_data[lane_lsb(i, DATA_W) +: DATA_W];
        assign lane_old[i] = bus.acc_first ? '0 : mem_q[bus.acc_addr][i];

        acc_lane_add #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_add (
            .a   (lane_old[i]),
            .b   (lane_in[i]),
            .sum (lane_sum[i]),
            .ovf (lane_ovf[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        lane_ptr_d  = lane_ptr_q;
        rows_left_d = rows_left_q;
        clear_d     = clear_q;
        overflow_d  = overflow_q;
        acc_fire    = 1'b0;
        clr_fire    = 1'b0;

        unique case (state_q)
            ACC_IDLE: begin
                acc_fire = bus.acc_valid;
                if (bus.drain_start) begin
                    state_d     = ACC_DRAIN;
                    row_ptr_d   = bus.drain_base;
                    lane_ptr_d  = '0;
                    rows_left_d = (bus.drain_rows == '0) ? RowsW'(DEPTH) : bus.drain_rows;
                    clear_d     = bus.drain_clear;
                    overflow_d  = 1'b0;
                end
                // A same-cycle overflowing beat still marks the flag after the drain clears it.
                if (acc_fire && (|lane_ovf)) begin
                    overflow_d = 1'b1;
                end
            end
            ACC_DRAIN: begin
                clr_fire = bus.out_ready && clear_q;
                if (bus.out_ready) begin
                    if (lane_ptr_q == LaneMax) begin
                        lane_ptr_d  = '0;
                        row_ptr_d   = row_ptr_q + 1'b1;
                        rows_left_d = rows_left_q - 1'b1;
                        if (rows_left_q == RowsW'(1)) begin
                            state_d = ACC_IDLE;
                        end
                    end else begin
                        lane_ptr_d = lane_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ACC_IDLE;
            row_ptr_q   <= '0;
            lane_ptr_q  <= '0;
            rows_left_q <= '0;
            clear_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            lane_ptr_q  <= lane_ptr_d;
            rows_left_q <= rows_left_d;
            clear_q     <= clear_d;
            overflow_q  <= overflow_d;
        end
    end

    // Accumulate writes happen only in IDLE and clear-on-read only in DRAIN, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                for (int l = 0; l < ARR_SIZE; l++) begin
                    mem_q[r][l] <= '0;
                end
            end
        end else begin
            if (acc_fire) begin
                for (int l = 0; l < ARR_SIZE; l++) begin
                    mem_q[bus.acc_addr][l] <= lane_sum[l];
                end
            end
            if (clr_fire) begin
                mem_q[row_ptr_q][lane_ptr_q] <= '0;
            end
        end
    end

    assign bus.acc_ready = (state_q == ACC_IDLE);
    assign bus.busy      = (state_q != ACC_IDLE);
    assign bus.out_valid = (state_q == ACC_DRAIN);
    assign bus.out_last  = (state_q == ACC_DRAIN) && (lane_ptr_q == LaneMax) &&
                           (rows_left_q == RowsW'(1));
    assign bus.out_data  = mem_q[row_ptr_q][lane_ptr_q];
    assign bus.out_addr  = {row_ptr_q, lane_ptr_q};
    assign bus.overflow  = overflow_q;

endmodule

// File: doc/accumulator_array.md
# accumulator_array

Parametrised successor to the single-row accumulator. It holds DEPTH rows of ARR_SIZE signed lane sums, with per-beat add-or-overwrite, optional saturation and a sticky overflow flag. It drains a chosen row range to the output buffer as a valid/ready word stream, optionally zeroing each word as it is sent. It sits between the MAC array column outputs and output_buffer, and takes its accumulate and drain commands from the controller.

## Interface
- ARR_SIZE, 4: lanes per row (MAC columns).
- DATA_W, 32: lane width, two's complement.
- DEPTH, 16: rows; must be a power of two, at least 2.
- SATURATE, 0: 0 = wrap-around add; 1 = signed saturating add.
- ADDR_W, $clog2(DEPTH): derived, not overridden.
- LANE_W, $clog2(ARR_SIZE) (minimum 1): derived, not overridden.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted (0) clears all state.
- acc_valid  in  1  accumulate beat present.
- acc_ready  out  1  high only in IDLE; a beat transfers when acc_valid && acc_ready.
- acc_first  in  1  the beat overwrites the row instead of adding to it.
- acc_addr  in  ADDR_W  target row.
- acc_data  in  ARR_SIZE*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- drain_start  in  1  one-cycle drain request; sampled only in IDLE.
- drain_base  in  ADDR_W  first row to drain.
- drain_rows  in  ADDR_W+1  row count; 0 is treated as DEPTH.
- drain_clear  in  1  zero each word once it has been sent.
- out_valid  out  1  output word present.
- out_ready  in  1  output buffer accepts the word.
- out_data  out  DATA_W  lane value.
- out_addr  out  ADDR_W+LANE_W  {row, lane}.
- out_last  out  1  final word of the drain.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky saturation/wrap indicator.

## Operation
- Storage: DEPTH×ARR_SIZE registers of DATA_W bits.
- States: IDLE and DRAIN.
  - IDLE → DRAIN when drain_start is high.
  - DRAIN → IDLE when the word with out_last is accepted.
- Accumulate (IDLE only): on transfer, row[acc_addr][i] <= (acc_first ? 0 : row[acc_addr][i]) + lane_i.
  - The add is computed at DATA_W+1 bits.
  - Signed overflow happens when the operands share a sign and the result sign differs.
  - SATURATE=1: an overflowing lane clamps to +2^(DATA_W-1)-1 or -2^(DATA_W-1).
  - SATURATE=0: the result wraps modulo 2^DATA_W.
  - In both modes any overflowing lane sets overflow.
- Drain:
  - On drain_start, latch drain_base, drain_rows and drain_clear, clear overflow, and zero the lane counter.
  - Words go out row-major, lane 0 first, for a total of rows×ARR_SIZE words.
  - The row pointer increments modulo DEPTH, so base+rows > DEPTH wraps to row 0.
  - out_data and out_addr come straight from storage at {row_ptr, lane_ptr}; they are held stable while out_valid && !out_ready.
  - With the latched clear bit set, an accepted word's register is written to 0 in the same cycle.
- Simultaneous drain_start and acc beat in IDLE:
  - Both are taken.
  - The drain's first word reflects the updated value.
- drain_start while in DRAIN is ignored; the controller must wait for !busy.
- Reset mid-drain: async clear of all storage and flags, return to IDLE, out_valid=0 immediately.

## Timing
- Reset values: acc_ready=1, busy=0, out_valid=0, out_last=0, out_data=0, out_addr=0, overflow=0, all storage 0.
- Accumulate: the write lands at the transfer edge; a read or accumulate of the same row on the next cycle sees the new value. Back-to-back beats to one row run at 1 per cycle.
- Drain:
  - out_valid rises the cycle after drain_start.
  - With out_ready held high, throughput is 1 word per cycle.
  - acc_ready returns 1 the cycle after the last word is accepted.
- out_ready low stalls the pointer; there are no drops and no duplicates.

## Structure
- Shared package acc_pkg holds:
  - the state enum (ACC_IDLE, ACC_DRAIN);
  - the saturation limit function sat_max/sat_min(DATA_W);
  - the lane-slice helper.
- One sub-module, acc_lane_add: a combinational DATA_W signed adder with a SATURATE parameter. It outputs sum and ovf and is instantiated ARR_SIZE times.
- The FSM, pointers and storage stay in accumulator_array.

## Test plan
- Reset then drain of 16 rows → 64 words, all 0, out_addr 0..63, out_last on word 63, overflow=0.
- Accumulate row 3 with lanes {1,2,3,4} using acc_first, then {10,20,30,40} using add; drain base=3, rows=1 → 11,22,33,44 with out_addr 12..15.
- SATURATE=1: row 0 lane 0 starts at 0x7FFFFFF0, add 0x20 → 0x7FFFFFFF and overflow=1. SATURATE=0: same stimulus → 0x80000010 and overflow=1. A following drain_start clears overflow.
- Drain base=14, rows=4, drain_clear=1, out_ready toggling 1,0,0,1 → rows 14,15,0,1 emitted in order with values stable through stalls; a second drain of the same rows reads all zeros.
- drain_start in the same cycle as an acc beat to the base row → the first word includes the beat. A drain_start issued mid-drain is ignored. acc_valid during DRAIN sees acc_ready=0 and storage unchanged.
- Reset asserted after 5 of 8 words → out_valid falls immediately and busy=0. After release, a drain returns zeros.
